// File: rtl/bod_pkg.sv
// Shared types and default sizing for the brownout level detector.
package bod_pkg;

    // Supply classification, ordered from healthy to brownout.
    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        WARN   = 2'd1,
        CRIT   = 2'd2
    } bod_state_e;

    localparam int ADC_W_DEF   = 20;
    localparam int DEB_CNT_DEF = 4;

endpackage

// File: rtl/bod_debounce_ctr.sv
// Consecutive-sample debounce counter.
// done pulses combinationally on the valid cycle that carries the
// DEB_CNT-th consecutive qualifying sample, so the owner can change state
// on the same posedge that registers that sample. A valid sample that does
// not qualify restarts the run; non-valid cycles hold the count.
import bod_pkg::*;

module bod_debounce_ctr #(
    parameter int DEB_CNT = DEB_CNT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic valid,
    input  logic qualify,
    input  logic clear,
    output logic done
);

    localparam int CW = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEB_CNT - 1);

    logic [CW-1:0] cnt;

    assign done = valid & qualify & (cnt == LAST);

    // Run-length of qualifying samples; clear wins so a state change restarts both paths.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            cnt <= '0;
        end else if (valid) begin
            if (!qualify) begin
                cnt <= '0;
            end else if (cnt != LAST) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/bod_level_detector.sv
// Brownout level detector: classifies rail samples into NORMAL / WARN / CRIT
// with hysteresis and debounce, and forces the critical flag when the ADC
// stops delivering samples.
//
// Handshake: adc_valid is a single-cycle strobe with no back-pressure; every
// cycle it is high, adc_in is consumed. Outputs are all registered and move
// on the posedge that consumes the qualifying sample.
import bod_pkg::*;

module bod_level_detector #(
    parameter int ADC_W     = ADC_W_DEF,
    parameter int DEB_CNT   = DEB_CNT_DEF,
    parameter int STALE_CYC = 1024,
    parameter int EVT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ADC_W-1:0] adc_in,
    input  logic             adc_valid,
    input  logic [ADC_W-1:0] warn_th,
    input  logic [ADC_W-1:0] crit_th,
    input  logic [ADC_W-1:0] hyst,
    output logic [ADC_W-1:0] adc_out,
    output logic             BOD_out1,
    output logic             BOD_out2,
    output logic             adc_stale,
    output logic             cfg_err,
    output logic [EVT_W-1:0] crit_events,
    output bod_state_e       dbg_state
);

    localparam int SW = $clog2(STALE_CYC + 1);
    localparam logic [SW-1:0] STALE_MAX = SW'(STALE_CYC);

    bod_state_e state_q;
    bod_state_e state_d;
    logic       state_chg;

    logic [ADC_W:0] crit_exit_lvl;
    logic [ADC_W:0] warn_exit_lvl;
    logic           c_low;
    logic           w_low;
    logic           c_high;
    logic           w_high;

    logic dn_qual;
    logic up_qual;
    logic dn_done;
    logic up_done;

    logic [SW-1:0] stale_cnt;

    // Exit levels carry one extra bit so threshold+hyst never wraps; a level
    // above full scale is simply unreachable.
    assign crit_exit_lvl = {1'b0, crit_th} + {1'b0, hyst};
    assign warn_exit_lvl = {1'b0, warn_th} + {1'b0, hyst};

    assign c_low  = adc_in < crit_th;
    assign w_low  = adc_in < warn_th;
    assign c_high = {1'b0, adc_in} >= crit_exit_lvl;
    assign w_high = {1'b0, adc_in} >= warn_exit_lvl;

    // Route qualifiers to the two debounce paths and pick the next state.
    // In NORMAL the upward path is otherwise idle, so it tracks the run of
    // critical-low samples while the downward path tracks warning-low ones;
    // a w_low-but-not-c_low sample therefore clears crit progress only.
    always_comb begin
        dn_qual = 1'b0;
        up_qual = 1'b0;
        state_d = state_q;
        case (state_q)
            NORMAL: begin
                dn_qual = w_low;
                up_qual = c_low;
                if (up_done) begin
                    state_d = CRIT;
                end else if (dn_done) begin
                    state_d = WARN;
                end
            end
            WARN: begin
                dn_qual = c_low;
                up_qual = w_high;
                if (dn_done) begin
                    state_d = CRIT;
                end else if (up_done) begin
                    state_d = NORMAL;
                end
            end
            CRIT: begin
                up_qual = c_high;
                if (up_done) begin
                    state_d = WARN;
                end
            end
            default: begin
                state_d = NORMAL;
            end
        endcase
    end

    assign state_chg = (state_d != state_q);

    bod_debounce_ctr #(
        .DEB_CNT (DEB_CNT)
    ) u_dn_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid   (adc_valid),
        .qualify (dn_qual),
        .clear   (state_chg),
        .done    (dn_done)
    );

    bod_debounce_ctr #(
        .DEB_CNT (DEB_CNT)
    ) u_up_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid   (adc_valid),
        .qualify (up_qual),
        .clear   (state_chg),
        .done    (up_done)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= NORMAL;
        end else begin
            state_q <= state_d;
        end
    end

    // Sample register, aligned with the flags it produced.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            adc_out <= '0;
        end else if (adc_valid) begin
            adc_out <= adc_in;
        end
    end

    // Cycles since the last sample, saturating at the stale limit.
    always_ff @(posedge clk) begin
        if (!rst_n || adc_valid) begin
            stale_cnt <= '0;
        end else if (stale_cnt != STALE_MAX) begin
            stale_cnt <= stale_cnt + SW'(1);
        end
    end

    // Saturating count of entries into CRIT; stale does not count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            crit_events <= '0;
        end else if (state_d == CRIT && state_q != CRIT && crit_events != '1) begin
            crit_events <= crit_events + EVT_W'(1);
        end
    end

    // Threshold ordering check; informational only, both paths keep running.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= (crit_th >= warn_th);
        end
    end

    assign adc_stale = (stale_cnt == STALE_MAX);
    assign BOD_out1  = (state_q != NORMAL) | adc_stale;
    assign BOD_out2  = (state_q == CRIT) | adc_stale;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_bod_level_detector.sv
// Directed bench for bod_level_detector with a sample-history reference model
// compared on every cycle, plus hand-computed literal expectations.
import bod_pkg::*;

module tb_bod_level_detector;

    localparam int ADC_W   = 20;
    localparam int DEB     = 4;
    localparam int STALE   = 16;
    localparam int EVT_W   = 2;
    localparam int EVT_MAX = (1 << EVT_W) - 1;

    localparam int M_NORMAL = 0;
    localparam int M_WARN   = 1;
    localparam int M_CRIT   = 2;

    // Predicate selectors for the history model.
    localparam int P_CLOW  = 0;
    localparam int P_WLOW  = 1;
    localparam int P_CHIGH = 2;
    localparam int P_WHIGH = 3;

    // ---------------- clock / reset / DUT ----------------
    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [ADC_W-1:0] adc_in = '0;
    logic             adc_valid = 1'b0;
    logic [ADC_W-1:0] warn_th = 20'd800000;
    logic [ADC_W-1:0] crit_th = 20'd600000;
    logic [ADC_W-1:0] hyst = 20'd20000;

    logic [ADC_W-1:0] adc_out;
    logic             BOD_out1;
    logic             BOD_out2;
    logic             adc_stale;
    logic             cfg_err;
    logic [EVT_W-1:0] crit_events;
    bod_state_e       dbg_state;

    always #5 clk = ~clk;

    bod_level_detector #(
        .ADC_W     (ADC_W),
        .DEB_CNT   (DEB),
        .STALE_CYC (STALE),
        .EVT_W     (EVT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .adc_in      (adc_in),
        .adc_valid   (adc_valid),
        .warn_th     (warn_th),
        .crit_th     (crit_th),
        .hyst        (hyst),
        .adc_out     (adc_out),
        .BOD_out1    (BOD_out1),
        .BOD_out2    (BOD_out2),
        .adc_stale   (adc_stale),
        .cfg_err     (cfg_err),
        .crit_events (crit_events),
        .dbg_state   (dbg_state)
    );

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // The model keeps the samples seen since the current state was entered
    // and moves when the most recent DEB of them all satisfy a rule.
    logic [ADC_W-1:0] hist[$];
    int               m_state  = M_NORMAL;
    int               m_next   = M_NORMAL;
    int               m_idle   = 0;
    int               m_events = 0;
    logic [ADC_W-1:0] m_out    = '0;
    logic             m_cfg    = 1'b0;
    bit               m_ready  = 1'b0;

    function automatic bit pred(input int kind, input logic [ADC_W-1:0] s);
        longint sv;
        sv = longint'(s);
        case (kind)
            P_CLOW:  return sv < longint'(crit_th);
            P_WLOW:  return sv < longint'(warn_th);
            P_CHIGH: return sv >= longint'(crit_th) + longint'(hyst);
            default: return sv >= longint'(warn_th) + longint'(hyst);
        endcase
    endfunction

    function automatic bit last_all(input int kind);
        if (hist.size() < DEB) return 1'b0;
        for (int i = hist.size() - DEB; i < hist.size(); i++) begin
            if (!pred(kind, hist[i])) return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            hist.delete();
            m_state  = M_NORMAL;
            m_idle   = 0;
            m_events = 0;
            m_out    = '0;
            m_cfg    = 1'b0;
            m_ready  = 1'b1;
        end else begin
            m_cfg = (crit_th >= warn_th);
            if (adc_valid) begin
                m_idle = 0;
                m_out  = adc_in;
                hist.push_back(adc_in);
                if (hist.size() > DEB) void'(hist.pop_front());
                m_next = m_state;
                if (m_state == M_NORMAL) begin
                    if (last_all(P_CLOW)) m_next = M_CRIT;
                    else if (last_all(P_WLOW)) m_next = M_WARN;
                end else if (m_state == M_WARN) begin
                    if (last_all(P_CLOW)) m_next = M_CRIT;
                    else if (last_all(P_WHIGH)) m_next = M_NORMAL;
                end else begin
                    if (last_all(P_CHIGH)) m_next = M_WARN;
                end
                if (m_next != m_state) begin
                    hist.delete();
                    if (m_next == M_CRIT && m_events < EVT_MAX) m_events++;
                    m_state = m_next;
                end
            end else if (m_idle < STALE) begin
                m_idle++;
            end
        end
    end

    // Per-cycle compare, away from the active edge.
    always @(negedge clk) begin
        if (m_ready) begin
            check("cyc.out1", 32'(BOD_out1), 32'((m_state != M_NORMAL) || (m_idle >= STALE)));
            check("cyc.out2", 32'(BOD_out2), 32'((m_state == M_CRIT) || (m_idle >= STALE)));
            check("cyc.stale", 32'(adc_stale), 32'(m_idle >= STALE));
            check("cyc.adc_out", 32'(adc_out), 32'(m_out));
            check("cyc.events", 32'(crit_events), 32'(m_events));
            check("cyc.cfg_err", 32'(cfg_err), 32'(m_cfg));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [ADC_W-1:0] s, input int n);
        repeat (n) begin
            adc_in    = s;
            adc_valid = 1'b1;
            @(negedge clk);
            adc_valid = 1'b0;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic lit(input string tag, input logic e1, input logic e2, input logic es,
                       input logic [ADC_W-1:0] eo, input int ev);
        check({tag, ".out1"}, 32'(BOD_out1), 32'(e1));
        check({tag, ".out2"}, 32'(BOD_out2), 32'(e2));
        check({tag, ".stale"}, 32'(adc_stale), 32'(es));
        check({tag, ".adc_out"}, 32'(adc_out), 32'(eo));
        check({tag, ".events"}, 32'(crit_events), 32'(ev));
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        lit("reset", 0, 0, 0, 20'd0, 0);
        check("reset.cfg_err", 32'(cfg_err), 32'd0);

        // Warning entry, then both boundaries inside WARN.
        send(20'd700000, 3);
        lit("warn_pre", 0, 0, 0, 20'd700000, 0);
        send(20'd700000, 1);
        lit("warn_entry", 1, 0, 0, 20'd700000, 0);
        send(20'd600000, 4);
        lit("crit_th_edge", 1, 0, 0, 20'd600000, 0);
        send(20'd820000, 4);
        lit("warn_exit", 0, 0, 0, 20'd820000, 0);

        // Sample equal to warn_th never qualifies.
        send(20'd800000, 4);
        lit("warn_th_edge", 0, 0, 0, 20'd800000, 0);

        // Debounce break.
        send(20'd700000, 3);
        send(20'd900000, 1);
        send(20'd700000, 3);
        lit("deb_break", 0, 0, 0, 20'd700000, 0);
        send(20'd700000, 1);
        lit("deb_resume", 1, 0, 0, 20'd700000, 0);
        send(20'd820000, 4);

        // Direct critical and hysteresis walk back down.
        send(20'd500000, 4);
        lit("direct_crit", 1, 1, 0, 20'd500000, 1);
        send(20'd610000, 4);
        lit("crit_hold", 1, 1, 0, 20'd610000, 1);
        send(20'd620000, 4);
        lit("crit_exit", 1, 0, 0, 20'd620000, 1);
        send(20'd820000, 4);
        lit("normal_again", 0, 0, 0, 20'd820000, 1);

        // Stale watchdog.
        repeat (16) @(negedge clk);
        lit("stale", 1, 1, 1, 20'd820000, 1);
        adc_in    = 20'd900000;
        adc_valid = 1'b1;
        @(negedge clk);
        adc_valid = 1'b0;
        lit("stale_clear", 0, 0, 0, 20'd900000, 1);
        repeat (4) @(negedge clk);

        // Reset mid-debounce discards progress.
        send(20'd700000, 3);
        pulse_reset();
        lit("mid_reset", 0, 0, 0, 20'd0, 0);
        send(20'd700000, 3);
        lit("post_reset3", 0, 0, 0, 20'd700000, 0);
        send(20'd700000, 1);
        lit("post_reset4", 1, 0, 0, 20'd700000, 0);
        send(20'd820000, 4);

        // Event counter saturation: four entries into CRIT.
        send(20'd500000, 4);
        for (int k = 0; k < 3; k++) begin
            send(20'd620000, 4);
            send(20'd500000, 4);
        end
        lit("evt_sat", 1, 1, 0, 20'd500000, 3);

        // Configuration error flag.
        crit_th = 20'd900000;
        @(negedge clk);
        check("cfg_err.set", 32'(cfg_err), 32'd1);
        crit_th = 20'd600000;
        @(negedge clk);
        check("cfg_err.clr", 32'(cfg_err), 32'd0);

        // Exit level above full scale is never reached.
        pulse_reset();
        warn_th = 20'hFFFF0;
        hyst    = 20'h00100;
        send(20'd700000, 4);
        send(20'hFFFFF, 4);
        lit("no_wrap", 1, 0, 0, 20'hFFFFF, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
